// File: rtl/apexii_ddio_out_burst_ctrl.sv
// Burst sequencer for a bank of APEX II DDIO output atoms.
// Frames each burst with oe-high preamble/postamble idle cycles.
module apexii_ddio_out_burst_ctrl #(
    parameter int   WIDTH     = 8,
    parameter int   LEN_W     = 8,
    parameter int   PREAMBLE  = 1,
    parameter int   POSTAMBLE = 1,
    parameter logic IDLE_H    = 1'b0,
    parameter logic IDLE_L    = 1'b0
) (
    input  logic             clk,
    input  logic             sreset,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [LEN_W-1:0] cmd_len,
    input  logic             data_valid,
    output logic             data_ready,
    input  logic [WIDTH-1:0] data_h,
    input  logic [WIDTH-1:0] data_l,
    output logic [WIDTH-1:0] ddio_datain_h,
    output logic [WIDTH-1:0] ddio_datain_l,
    output logic             ddio_clkena,
    output logic             ddio_oe,
    output logic             busy,
    output logic [7:0]       underrun_cnt
);

    typedef enum logic [1:0] {IDLE, PRE, BURST, POST} state_t;

    localparam logic [3:0]   PRE_N  = 4'(PREAMBLE);
    localparam logic [3:0]   POST_N = 4'(POSTAMBLE);
    localparam logic [LEN_W:0] ONE  = (LEN_W+1)'(1);

    state_t         state, state_nx;
    logic [LEN_W:0] cnt, cnt_nx;
    logic [3:0]     ph, ph_nx;
    logic           accept, xfer, stall;

    assign accept     = cmd_valid & cmd_ready;
    assign data_ready = (state == BURST);
    assign xfer       = data_ready & data_valid;
    assign stall      = data_ready & ~data_valid;

    always_comb begin
        state_nx = state;
        cnt_nx   = cnt;
        ph_nx    = ph;
        case (state)
            IDLE: begin
                if (accept) begin
                    cnt_nx   = {1'b0, cmd_len} + ONE;
                    ph_nx    = PRE_N;
                    state_nx = (PREAMBLE > 0) ? PRE : BURST;
                end
            end
            PRE: begin
                if (ph <= 4'd1) state_nx = BURST;
                else            ph_nx    = ph - 4'd1;
            end
            BURST: begin
                if (xfer) begin
                    cnt_nx = cnt - ONE;
                    if (cnt == ONE) begin
                        ph_nx    = POST_N;
                        state_nx = (POSTAMBLE > 0) ? POST : IDLE;
                    end
                end
            end
            POST: begin
                if (ph <= 4'd1) state_nx = IDLE;
                else            ph_nx    = ph - 4'd1;
            end
            default: state_nx = IDLE;
        endcase
    end

    // oe also covers the cycle after leaving the last active state so
    // the final registered beat is still driven.
    always_ff @(posedge clk) begin
        if (sreset) begin
            state         <= IDLE;
            cnt           <= '0;
            ph            <= '0;
            cmd_ready     <= 1'b0;
            busy          <= 1'b0;
            ddio_oe       <= 1'b0;
            ddio_clkena   <= 1'b0;
            ddio_datain_h <= {WIDTH{IDLE_H}};
            ddio_datain_l <= {WIDTH{IDLE_L}};
            underrun_cnt  <= '0;
        end else begin
            state       <= state_nx;
            cnt         <= cnt_nx;
            ph          <= ph_nx;
            cmd_ready   <= (state == IDLE) && (state_nx == IDLE);
            busy        <= (state_nx != IDLE);
            ddio_oe     <= (state != IDLE) || (state_nx != IDLE);
            ddio_clkena <= ~stall;
            if (xfer) begin
                ddio_datain_h <= data_h;
                ddio_datain_l <= data_l;
            end else if (!stall) begin
                ddio_datain_h <= {WIDTH{IDLE_H}};
                ddio_datain_l <= {WIDTH{IDLE_L}};
            end
            if (stall && underrun_cnt != 8'hFF)
                underrun_cnt <= underrun_cnt + 8'd1;
        end
    end

endmodule

// File: tb/tb_apexii_ddio_out_burst_ctrl.sv
// Randomized bench for apexii_ddio_out_burst_ctrl: three instances with
// different preamble/postamble/idle settings checked against a timeline model.
module tb_apexii_ddio_out_burst_ctrl;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic [2:0] sreset, cmd_valid, data_valid;
    logic [2:0] cmd_ready, data_ready, clkena, oe, busy;
    logic [7:0] cmd_len [3];
    logic [7:0] data_h [3];
    logic [7:0] data_l [3];
    logic [7:0] out_h [3];
    logic [7:0] out_l [3];
    logic [7:0] ucnt [3];

    logic [7:0] bh [256];
    logic [7:0] bl [256];
    int ucnt_m [3];
    int pass_n = 0;
    int total_n = 0;

    function automatic int pre_of(int d);
        return d == 0 ? 1 : (d == 1 ? 0 : 3);
    endfunction
    function automatic int post_of(int d);
        return d == 0 ? 1 : (d == 1 ? 0 : 2);
    endfunction
    function automatic logic [7:0] idle_h(int d);
        return d == 1 ? 8'hFF : 8'h00;
    endfunction
    function automatic logic [7:0] idle_l(int d);
        return d == 2 ? 8'hFF : 8'h00;
    endfunction

    for (genvar g = 0; g < 3; g++) begin : g_dut
        apexii_ddio_out_burst_ctrl #(
            .WIDTH(8), .LEN_W(8),
            .PREAMBLE(g == 0 ? 1 : (g == 1 ? 0 : 3)),
            .POSTAMBLE(g == 0 ? 1 : (g == 1 ? 0 : 2)),
            .IDLE_H(g == 1 ? 1'b1 : 1'b0),
            .IDLE_L(g == 2 ? 1'b1 : 1'b0)
        ) u_dut (
            .clk(clk), .sreset(sreset[g]),
            .cmd_valid(cmd_valid[g]), .cmd_ready(cmd_ready[g]),
            .cmd_len(cmd_len[g]),
            .data_valid(data_valid[g]), .data_ready(data_ready[g]),
            .data_h(data_h[g]), .data_l(data_l[g]),
            .ddio_datain_h(out_h[g]), .ddio_datain_l(out_l[g]),
            .ddio_clkena(clkena[g]), .ddio_oe(oe[g]),
            .busy(busy[g]), .underrun_cnt(ucnt[g])
        );
    end

    // Burst-relative cycle j: 0 = outside burst, 1 = beat moves, 2 = stall.
    function automatic int kind(int j, int b, int ga, int gn);
        if (j < 0 || j >= b) return 0;
        if (gn > 0 && j >= ga && j < ga + gn) return 2;
        return 1;
    endfunction
    function automatic int beat_idx(int j, int ga, int gn);
        return (gn > 0 && j >= ga + gn) ? j - gn : j;
    endfunction

    task automatic test_reset();
        sreset = '1;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            for (int d = 0; d < 3; d++) begin
                total_n++;
                if (oe[d] !== 1'b0 || clkena[d] !== 1'b0 || busy[d] !== 1'b0
                    || cmd_ready[d] !== 1'b0 || ucnt[d] !== 8'd0
                    || out_h[d] !== idle_h(d) || out_l[d] !== idle_l(d))
                    $display("FAIL reset_vals d%0d: oe=%b ce=%b busy=%b rdy=%b u=%0d h=%h l=%h want 0 0 0 0 0 %h %h",
                             d, oe[d], clkena[d], busy[d], cmd_ready[d], ucnt[d],
                             out_h[d], out_l[d], idle_h(d), idle_l(d));
                else pass_n++;
            end
        end
        sreset = '0;
        @(negedge clk);
        for (int d = 0; d < 3; d++) begin
            ucnt_m[d] = 0;
            total_n++;
            if (cmd_ready[d] !== 1'b1 || oe[d] !== 1'b0 || clkena[d] !== 1'b1
                || data_ready[d] !== 1'b0 || busy[d] !== 1'b0)
                $display("FAIL post_reset d%0d: rdy=%b oe=%b ce=%b dr=%b busy=%b want 1 0 1 0 0",
                         d, cmd_ready[d], oe[d], clkena[d], data_ready[d], busy[d]);
            else pass_n++;
        end
    endtask

    // Issues one burst of len+1 beats from bh/bl; stalls gn cycles after
    // beat ga. rst_at > 0 asserts sreset in that cycle of the burst.
    task automatic run_burst(input int d, input int len, input int ga,
                             input int gn, input bit keep, input int rst_at);
        int p, q, b, e, j, jp, kp, stl, eu, w;
        logic [7:0] eh, el;
        p = pre_of(d);
        q = post_of(d);
        b = len + 1 + gn;
        e = p + b + q + 2;
        w = 0;
        while (cmd_ready[d] !== 1'b1 && w < 50) begin
            @(negedge clk);
            w++;
        end
        total_n++;
        if (cmd_ready[d] !== 1'b1) begin
            $display("FAIL cmd_ready_wait d%0d: got %b want 1", d, cmd_ready[d]);
            return;
        end
        pass_n++;
        cmd_len[d] = 8'(len);
        cmd_valid[d] = 1'b1;
        data_valid[d] = 1'($urandom);
        data_h[d] = 8'($urandom);
        data_l[d] = 8'($urandom);
        for (int c = 1; c <= e; c++) begin
            @(negedge clk);
            if (c == 1) cmd_valid[d] = keep;
            j = c - 1 - p;
            jp = c - 2 - p;
            kp = kind(jp, b, ga, gn);
            if (kp == 1) begin
                eh = bh[beat_idx(jp, ga, gn)];
                el = bl[beat_idx(jp, ga, gn)];
            end else if (kp == 2) begin
                eh = bh[ga-1];
                el = bl[ga-1];
            end else begin
                eh = idle_h(d);
                el = idle_l(d);
            end
            stl = (gn == 0) ? 0 : jp - ga + 1;
            if (stl < 0) stl = 0;
            if (stl > gn) stl = gn;
            eu = ucnt_m[d] + stl;
            if (eu > 255) eu = 255;
            total_n++;
            if (oe[d] !== 1'(c <= p + b + q + 1))
                $display("FAIL oe d%0d c%0d: got %b want %b", d, c, oe[d], c <= p + b + q + 1);
            else pass_n++;
            total_n++;
            if (busy[d] !== 1'(c <= p + b + q))
                $display("FAIL busy d%0d c%0d: got %b want %b", d, c, busy[d], c <= p + b + q);
            else pass_n++;
            total_n++;
            if (cmd_ready[d] !== 1'(c == e))
                $display("FAIL cmd_ready d%0d c%0d: got %b want %b", d, c, cmd_ready[d], c == e);
            else pass_n++;
            total_n++;
            if (data_ready[d] !== 1'(kind(j, b, ga, gn) != 0))
                $display("FAIL data_ready d%0d c%0d: got %b want %b", d, c, data_ready[d], kind(j, b, ga, gn) != 0);
            else pass_n++;
            total_n++;
            if (clkena[d] !== 1'(kp != 2))
                $display("FAIL clkena d%0d c%0d: got %b want %b", d, c, clkena[d], kp != 2);
            else pass_n++;
            total_n++;
            if (out_h[d] !== eh || out_l[d] !== el)
                $display("FAIL datain d%0d c%0d: got %h/%h want %h/%h", d, c, out_h[d], out_l[d], eh, el);
            else pass_n++;
            total_n++;
            if (ucnt[d] !== 8'(eu))
                $display("FAIL underrun_cnt d%0d c%0d: got %0d want %0d", d, c, ucnt[d], eu);
            else pass_n++;
            kp = kind(j, b, ga, gn);
            data_valid[d] = (kp == 0) ? 1'($urandom) : 1'(kp == 1);
            data_h[d] = (kp == 1) ? bh[beat_idx(j, ga, gn)] : 8'($urandom);
            data_l[d] = (kp == 1) ? bl[beat_idx(j, ga, gn)] : 8'($urandom);
            if (c == rst_at) begin
                sreset[d] = 1'b1;
                @(negedge clk);
                total_n++;
                if (oe[d] !== 1'b0 || busy[d] !== 1'b0 || data_ready[d] !== 1'b0
                    || clkena[d] !== 1'b0 || out_h[d] !== idle_h(d) || ucnt[d] !== 8'd0)
                    $display("FAIL mid_reset d%0d: oe=%b busy=%b dr=%b ce=%b h=%h u=%0d want 0 0 0 0 %h 0",
                             d, oe[d], busy[d], data_ready[d], clkena[d], out_h[d], idle_h(d), ucnt[d]);
                else pass_n++;
                sreset[d] = 1'b0;
                @(negedge clk);
                total_n++;
                if (cmd_ready[d] !== 1'b1 || data_ready[d] !== 1'b0 || oe[d] !== 1'b0)
                    $display("FAIL after_mid_reset d%0d: rdy=%b dr=%b oe=%b want 1 0 0",
                             d, cmd_ready[d], data_ready[d], oe[d]);
                else pass_n++;
                ucnt_m[d] = 0;
                return;
            end
        end
        ucnt_m[d] = (ucnt_m[d] + gn > 255) ? 255 : ucnt_m[d] + gn;
    endtask

    task automatic fill_random(input int n);
        for (int i = 0; i < n; i++) begin
            bh[i] = 8'($urandom);
            bl[i] = 8'($urandom);
        end
    endtask

    task automatic fill_fixed();
        bh[0] = 8'hA5; bl[0] = 8'h5A;
        bh[1] = 8'h01; bl[1] = 8'h02;
        bh[2] = 8'h03; bl[2] = 8'h04;
        bh[3] = 8'hFF; bl[3] = 8'h00;
    endtask

    task automatic test_single_burst();
        fill_fixed();
        run_burst(0, 3, 0, 0, 1'b0, 0);
    endtask

    task automatic test_underrun();
        fill_fixed();
        run_burst(0, 3, 2, 2, 1'b0, 0);
    endtask

    task automatic test_zero_amble();
        fill_random(1);
        run_burst(1, 0, 0, 0, 1'b0, 0);
    endtask

    task automatic test_back_to_back();
        for (int d = 0; d < 3; d++) begin
            fill_random(3);
            run_burst(d, 2, 0, 0, 1'b1, 0);
            fill_random(2);
            run_burst(d, 1, 0, 0, 1'b0, 0);
        end
    endtask

    task automatic test_random();
        int d, len, ga, gn;
        for (int i = 0; i < 24; i++) begin
            d = $urandom_range(0, 2);
            len = $urandom_range(0, 9);
            ga = 0;
            gn = 0;
            if (len > 0 && $urandom_range(0, 1) == 1) begin
                gn = $urandom_range(1, 4);
                ga = $urandom_range(1, len);
            end
            fill_random(len + 1);
            run_burst(d, len, ga, gn, 1'b0, 0);
        end
    endtask

    task automatic test_max_len();
        fill_random(256);
        run_burst(1, 255, 0, 0, 1'b0, 0);
    endtask

    task automatic test_saturate();
        fill_random(2);
        run_burst(2, 1, 1, 300, 1'b0, 0);
    endtask

    task automatic test_reset_mid();
        fill_random(8);
        run_burst(0, 7, 0, 0, 1'b0, pre_of(0) + 2);
        fill_random(2);
        run_burst(0, 1, 0, 0, 1'b0, 0);
    endtask

    initial begin
        sreset = '1;
        cmd_valid = '0;
        data_valid = '0;
        for (int d = 0; d < 3; d++) begin
            cmd_len[d] = '0;
            data_h[d] = '0;
            data_l[d] = '0;
            ucnt_m[d] = 0;
        end
        test_reset();
        test_single_burst();
        test_underrun();
        test_zero_amble();
        test_back_to_back();
        test_random();
        test_max_len();
        test_saturate();
        test_reset_mid();
        $display("%0d/%0d checks passed", pass_n, total_n);
        $finish;
    end

endmodule

// File: doc/apexii_ddio_out_burst_ctrl.md
# apexii_ddio_out_burst_ctrl

Burst sequencer for a bank of APEX II DDIO output atoms configured with `ddio_mode = "output"`. It accepts burst commands and a beat-wide data stream. Per lane, it drives the high/low data pair, clock enable and output enable, framing each burst with a preamble and a postamble. It sits between the core-side transmit logic and the DDIO output wrappers, one instance per source-synchronous output bus.

## Interface
- `WIDTH`, 8: number of DDIO output lanes.
- `LEN_W`, 8: width of `cmd_len`; max burst is 2^LEN_W beats.
- `PREAMBLE`, 1: cycles (0–15) of oe-high idle pattern before first beat.
- `POSTAMBLE`, 1: cycles (0–15) of oe-high idle pattern after last beat.
- `IDLE_H`, 1'b0: value driven on every lane's high half when not carrying data.
- `IDLE_L`, 1'b0: value driven on every lane's low half when not carrying data.

Ports:
- `clk` in 1: the only clock; also feeds the DDIO atoms' `clk`.
- `sreset` in 1: synchronous, active-high reset.
- `cmd_valid` in 1: burst request.
- `cmd_ready` out 1: command accepted when `cmd_valid & cmd_ready`.
- `cmd_len` in LEN_W: burst length minus one, in beats.
- `data_valid` in 1: beat available.
- `data_ready` out 1: beat consumed when `data_valid & data_ready`.
- `data_h` in WIDTH: rising-edge half of the beat.
- `data_l` in WIDTH: falling-edge half of the beat.
- `ddio_datain_h` out WIDTH: to the atoms' `datain_h`.
- `ddio_datain_l` out WIDTH: to the atoms' `datain_l`.
- `ddio_clkena` out 1: to every atom's `clkena`.
- `ddio_oe` out 1: to every atom's `oe`.
- `busy` out 1: high in any state other than IDLE.
- `underrun_cnt` out 8: saturating count of stall cycles.

## Operation
- States are IDLE, PRE, BURST, POST.
- Reset values, with `sreset` high at a clock edge:
  - state = IDLE and the beat counter is cleared.
  - `ddio_oe` = 0 and `ddio_clkena` = 0.
  - `ddio_datain_h` = {WIDTH{IDLE_H}} and `ddio_datain_l` = {WIDTH{IDLE_L}}.
  - `underrun_cnt` = 0, `cmd_ready` = 0, `busy` = 0.
- Reset mid-burst aborts at once. The beats left in the burst are not consumed.
- `cmd_ready` = (state == IDLE) & !sreset, registered; it reads 1 from the first cycle after reset releases.
- `data_ready` = (state == BURST). It is combinational from the state register.
- In IDLE: `ddio_oe` = 0, `ddio_clkena` = 1, idle pattern on the data outputs.
- On command acceptance, the latched length is `cmd_len` + 1 beats.
  - Next state is PRE if `PREAMBLE` > 0, otherwise BURST.
- PRE: `ddio_oe` = 1, `ddio_clkena` = 1, idle pattern. Lasts exactly `PREAMBLE` cycles, then BURST.
- BURST:
  - `ddio_oe` = 1.
  - On a beat transfer: `ddio_datain_h` <= `data_h`, `ddio_datain_l` <= `data_l`, `ddio_clkena` = 1, remaining count decrements.
  - When `data_valid` = 0 (underrun): `ddio_clkena` = 0 so the atoms hold their last beat, the data outputs hold, and `underrun_cnt` increments, saturating at 255.
  - After the last beat transfers, next state is POST if `POSTAMBLE` > 0, otherwise IDLE.
- POST: `ddio_oe` = 1, `ddio_clkena` = 1, idle pattern. Lasts exactly `POSTAMBLE` cycles, then IDLE.
- `cmd_valid` outside IDLE is ignored, because `cmd_ready` = 0. Back-to-back bursts therefore always have at least one IDLE cycle, with oe low, between them.
- `underrun_cnt` is cleared only by `sreset`.
- Widths: the beat counter is LEN_W+1 bits. With `cmd_len` = all-ones the burst is 2^LEN_W beats, with no wrap.

## Timing
- All `ddio_*` outputs, `cmd_ready`, `busy` and `underrun_cnt` are registered.
- Take the accept edge as cycle T:
  - `busy` = 1 and `ddio_oe` = 1 from T+1.
  - The first data beat appears on `ddio_datain_*` at T+1+PREAMBLE+1. The beat transfers in cycle T+1+PREAMBLE and is registered at the end of that cycle.
- With no underrun, a burst of N beats holds `ddio_oe` high for PREAMBLE+N+POSTAMBLE cycles, plus one cycle of output register latency on the last beat.
- Pad timing is not this block's concern: the atom adds its own output and oe register stage at the pad.
- `ddio_clkena` drops in the cycle after an underrun cycle is detected (registered). This gives hold behaviour at the atom one cycle later, consistent with the data path.

## Test plan
- Reset then idle. Drive `sreset` 1 for 3 cycles, then 0. Required: all outputs at reset values during reset, `cmd_ready` = 1 at the first post-reset edge, `ddio_oe` = 0.
- Single burst with PREAMBLE=1, POSTAMBLE=1, `cmd_len`=3, beats 0xA5/0x5A, 0x01/0x02, 0x03/0x04, 0xFF/0x00 with `data_valid` held high. Required:
  - `ddio_oe` high for 7 cycles;
  - the four beats appear in order on consecutive cycles;
  - idle pattern before and after;
  - `underrun_cnt` = 0.
- Underrun. Same burst, with `data_valid` deasserted for 2 cycles after beat 2. Required:
  - `ddio_clkena` = 0 for 2 cycles;
  - beat 2 held on the outputs;
  - `underrun_cnt` = 2;
  - `ddio_oe` stays 1 throughout.
- Zero preamble/postamble with `cmd_len` = 0. Required: one beat, and `ddio_oe` high for exactly 2 cycles.
- Back-to-back commands: `cmd_valid` held high with two commands queued. Required:
  - second command accepted only after return to IDLE;
  - exactly one `ddio_oe` = 0 cycle between bursts.
- Reset mid-burst: `sreset` asserted during beat 2 of an 8-beat burst. Required: next cycle `ddio_oe` = 0, `busy` = 0, and the remaining beats are not requested.
